// File: rtl/ifm_pkg.sv
// IFM buffer controller shared definitions.
// FSM states and buffer geometry constants.
package ifm_pkg;

    localparam int DEPTH_WORDS = 100352;
    localparam int WORD_W      = 32;
    localparam int BEAT_W      = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD_ISSUE,
        S_RD_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/ifm_rd_skid.sv
// Single-entry output slot for the read stream.
// Payload lives in the BRAM output register; the slot tracks occupancy.
module ifm_rd_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic valid_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = valid_q ? in_data : '0;

    // Slot fills on a new issue and empties when consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (in_valid) begin
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ifm_bram_ctrl.sv
// IFM BRAM controller: loads 128-bit beats, streams 32-bit words out.
// Stalled reads re-issue the held address so BRAM output stays stable.
module ifm_bram_ctrl #(
    parameter int DEPTH_WORDS = ifm_pkg::DEPTH_WORDS,
    parameter int ADDR_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic [ADDR_W-1:0]         load_base,
    input  logic [ADDR_W-1:0]         load_beats,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [ifm_pkg::BEAT_W-1:0] s_data,
    input  logic                      rd_start,
    input  logic [ADDR_W-1:0]         rd_base,
    input  logic [ADDR_W-1:0]         rd_len,
    output logic                      bram_wr_rd_en,
    output logic [ADDR_W-1:0]         bram_wr_addr,
    output logic [ADDR_W-1:0]         bram_rd_addr,
    output logic [ifm_pkg::BEAT_W-1:0] bram_data_in,
    input  logic [ifm_pkg::WORD_W-1:0] bram_data_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [ifm_pkg::WORD_W-1:0] m_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    import ifm_pkg::*;

    localparam int XW = ADDR_W + 3;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q, len_q, cnt_q, rd_addr_q;
    logic              err_q;
    logic [XW-1:0]     ld_end, rd_end;
    logic              ld_bad, rd_bad, last;
    logic              beat, issue, slot_ready, hs;

    assign ld_end = XW'(load_base) + (XW'(load_beats) << 2);
    assign rd_end = XW'(rd_base) + XW'(rd_len);
    assign ld_bad = ld_end > XW'(DEPTH_WORDS);
    assign rd_bad = rd_end > XW'(DEPTH_WORDS);
    assign last   = (cnt_q == len_q - ADDR_W'(1));
    assign hs     = m_valid && m_ready;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign err  = done && err_q;

    // Next state and per-cycle BRAM/stream strobes.
    always_comb begin
        state_nx      = state;
        s_ready       = 1'b0;
        beat          = 1'b0;
        issue         = 1'b0;
        bram_wr_rd_en = 1'b0;
        bram_data_in  = '0;
        bram_wr_addr  = base_q + (cnt_q << 2);
        bram_rd_addr  = rd_addr_q;
        unique case (state)
            S_IDLE: begin
                if (load_start) begin
                    if (ld_bad || load_beats == '0) state_nx = S_DONE;
                    else                            state_nx = S_LOAD;
                end else if (rd_start) begin
                    if (rd_bad || rd_len == '0) state_nx = S_DONE;
                    else                        state_nx = S_RD_ISSUE;
                end
            end
            S_LOAD: begin
                s_ready       = 1'b1;
                beat          = s_valid;
                bram_wr_rd_en = beat;
                if (beat) bram_data_in = s_data;
                if (beat && last) state_nx = S_DONE;
            end
            S_RD_ISSUE: begin
                issue = slot_ready;
                if (issue) bram_rd_addr = (base_q + cnt_q) << 2;
                if (issue && last) state_nx = S_RD_DRAIN;
            end
            S_RD_DRAIN: begin
                if (hs) state_nx = S_DONE;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State, latched operands, beat/word counter and held read address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            rd_addr_q <= bram_rd_addr;
            if (state == S_IDLE) begin
                if (load_start) begin
                    base_q <= load_base;
                    len_q  <= load_beats;
                    cnt_q  <= '0;
                    err_q  <= ld_bad;
                end else if (rd_start) begin
                    base_q <= rd_base;
                    len_q  <= rd_len;
                    cnt_q  <= '0;
                    err_q  <= rd_bad;
                end
            end else if (beat || issue) begin
                cnt_q <= cnt_q + ADDR_W'(1);
            end
        end
    end

    ifm_rd_skid #(.W(WORD_W)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_ready  (slot_ready),
        .in_data   (bram_data_out),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data)
    );

endmodule

// File: tb/tb_ifm_bram_ctrl.sv
// Randomized bench for ifm_bram_ctrl with a BRAM model and word-level reference.
// Expected words come from a reference memory updated from the stimulus.
module tb_ifm_bram_ctrl;

    localparam int DEPTH = 100352;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_start = 1'b0;
    logic [31:0]  load_base = '0;
    logic [31:0]  load_beats = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] s_data = '0;
    logic         rd_start = 1'b0;
    logic [31:0]  rd_base = '0;
    logic [31:0]  rd_len = '0;
    logic         bram_wr_rd_en;
    logic [31:0]  bram_wr_addr;
    logic [31:0]  bram_rd_addr;
    logic [127:0] bram_data_in;
    logic [31:0]  bram_data_out = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [31:0]  m_data;
    logic         busy, done, err;

    int n_chk = 0;
    int n_bad = 0;
    int n_wr_seen = 0;
    int n_rd_seen = 0;
    int n_wr_exp = 0;
    int n_rd_exp = 0;

    logic [31:0] bmem[int];
    logic [31:0] ref_mem[int];

    ifm_bram_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .load_base     (load_base),
        .load_beats    (load_beats),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .rd_start      (rd_start),
        .rd_base       (rd_base),
        .rd_len        (rd_len),
        .bram_wr_rd_en (bram_wr_rd_en),
        .bram_wr_addr  (bram_wr_addr),
        .bram_rd_addr  (bram_rd_addr),
        .bram_data_in  (bram_data_in),
        .bram_data_out (bram_data_out),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_pat(input int a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic logic [31:0] bm_rd(input int a);
        if (bmem.exists(a)) return bmem[a];
        return init_pat(a);
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_pat(a);
    endfunction

    // BRAM model: 128-bit write port, registered 32-bit read port.
    always @(posedge clk) begin
        if (bram_wr_rd_en)
            for (int j = 0; j < 4; j++)
                bmem[int'(bram_wr_addr) + j] = bram_data_in[32*j +: 32];
        bram_data_out <= bm_rd(int'(bram_rd_addr >> 2));
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bram_wr_rd_en) n_wr_seen++;
            if (m_valid && m_ready) n_rd_seen++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        @(posedge clk); #1;
    endtask

    // mode: 0 always-valid, 1 random valid; also_rd raises rd_start too.
    task automatic do_load(input logic [31:0] base, input logic [31:0] beats,
                           input int mode, input bit also_rd);
        logic [35:0] endw;
        bit          bad;
        int          k, c;
        logic [31:0] ea;
        endw = {4'b0, base} + ({4'b0, beats} << 2);
        bad  = endw > 36'(DEPTH);
        @(posedge clk); #1;
        load_start = 1'b1; load_base = base; load_beats = beats;
        rd_start = also_rd; rd_base = base; rd_len = 32'd3;
        @(posedge clk); #1;
        load_start = 1'b0; rd_start = 1'b0;
        if (bad || beats == 0) begin
            @(negedge clk);
            chk("ld_done_imm", done, 1'b1);
            chk("ld_err", err, bad);
            chk("ld_nowr", bram_wr_rd_en, 1'b0);
            @(posedge clk); #1;
            idle_check();
            return;
        end
        k = 0; c = 0;
        while (k < int'(beats) && c < 400) begin
            s_valid = (mode == 0) ? 1'b1 : ($urandom % 4 != 0);
            s_data  = {$urandom, $urandom, $urandom, $urandom};
            rd_start = ($urandom % 8 == 0);
            rd_base = $urandom % 64; rd_len = 32'd2;
            @(negedge clk);
            chk("ld_sready", s_ready, 1'b1);
            chk("ld_wren", bram_wr_rd_en, s_valid);
            chk("ld_mvalid", m_valid, 1'b0);
            if (s_valid) begin
                ea = base + 32'(k * 4);
                chk("ld_waddr", bram_wr_addr, ea);
                chk("ld_wdata", bram_data_in, s_data);
                for (int j = 0; j < 4; j++)
                    ref_mem[int'(ea) + j] = s_data[32*j +: 32];
                n_wr_exp++;
                k++;
            end
            c++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; rd_start = 1'b0;
        if (c >= 400) chk("ld_timeout", 1'b1, 1'b0);
        @(negedge clk);
        chk("ld_done", done, 1'b1);
        chk("ld_err0", err, 1'b0);
        chk("ld_sready0", s_ready, 1'b0);
        @(posedge clk); #1;
        idle_check();
    endtask

    // mode: 0 always ready, 1 random ready, 2 ready pattern 1,0,0,1.
    task automatic do_read(input logic [31:0] base, input logic [31:0] len,
                           input int mode);
        logic [35:0] endw;
        bit          bad;
        int          got, c;
        logic [31:0] ea;
        bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        endw = {4'b0, base} + {4'b0, len};
        bad  = endw > 36'(DEPTH);
        @(posedge clk); #1;
        rd_start = 1'b1; rd_base = base; rd_len = len;
        @(posedge clk); #1;
        rd_start = 1'b0;
        if (bad || len == 0) begin
            @(negedge clk);
            chk("rd_done_imm", done, 1'b1);
            chk("rd_err", err, bad);
            chk("rd_no_mvalid", m_valid, 1'b0);
            @(posedge clk); #1;
            idle_check();
            return;
        end
        got = 0; c = 0;
        while (got < int'(len) && c < 400) begin
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = ($urandom % 10 < 7);
                default: m_ready = pat[c % 4];
            endcase
            @(negedge clk);
            if (mode == 0) begin
                if (c < int'(len)) begin
                    ea = (base + 32'(c)) << 2;
                    chk("rd_addr", bram_rd_addr, ea);
                end
                chk("rd_lat_mvalid", m_valid, c >= 1);
            end
            if (m_valid) chk("rd_data", m_data, ref_word(int'(base) + got));
            if (m_valid && m_ready) got++;
            chk("rd_nowr", bram_wr_rd_en, 1'b0);
            c++;
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        if (c >= 400) chk("rd_timeout", 1'b1, 1'b0);
        n_rd_exp += int'(len);
        @(negedge clk);
        chk("rd_done", done, 1'b1);
        chk("rd_err0", err, 1'b0);
        chk("rd_mvalid0", m_valid, 1'b0);
        @(posedge clk); #1;
        idle_check();
    endtask

    initial begin
        int beats, base, len;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_sready", s_ready, 1'b0);
        chk("rst_mvalid", m_valid, 1'b0);
        chk("rst_wren", bram_wr_rd_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_waddr", bram_wr_addr, 32'd0);
        chk("rst_raddr", bram_rd_addr, 32'd0);
        chk("rst_mdata", m_data, 32'd0);
        @(posedge clk); #1;

        do_load(32'd8, 32'd3, 0, 1'b0);
        do_read(32'd5, 32'd4, 0);
        do_read(32'd5, 32'd4, 2);
        do_read(32'd8, 32'd12, 1);
        do_read(32'd100350, 32'd4, 0);
        do_read(32'd10, 32'd0, 0);
        do_read(32'hFFFF_FFFF, 32'd2, 0);
        do_read(32'd100348, 32'd4, 0);
        do_load(32'd0, 32'd0, 0, 1'b0);
        do_load(32'd100348, 32'd1, 0, 1'b0);
        do_load(32'd100349, 32'd1, 0, 1'b0);
        do_load(32'd200, 32'd2, 0, 1'b1);
        do_read(32'd200, 32'd8, 1);
        do_read(32'd100346, 32'd6, 2);

        // Reset after the first of four beats.
        @(posedge clk); #1;
        load_start = 1'b1; load_base = 32'd40; load_beats = 32'd4;
        @(posedge clk); #1;
        load_start = 1'b0;
        s_valid = 1'b1; s_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("rl_wren", bram_wr_rd_en, 1'b1);
        chk("rl_waddr", bram_wr_addr, 32'd40);
        for (int j = 0; j < 4; j++) ref_mem[40 + j] = s_data[32*j +: 32];
        n_wr_exp++;
        @(posedge clk); #1;
        s_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("rl_sready", s_ready, 1'b0);
            chk("rl_nowr", bram_wr_rd_en, 1'b0);
            chk("rl_busy", busy, 1'b0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        do_read(32'd40, 32'd8, 1);

        // Reset while a read is stalled.
        rd_start = 1'b1; rd_base = 32'd60; rd_len = 32'd8; m_ready = 1'b0;
        @(posedge clk); #1;
        rd_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rr_mvalid", m_valid, 1'b0);
            chk("rr_busy", busy, 1'b0);
            @(posedge clk); #1;
        end
        m_ready = 1'b0;

        repeat (16) begin
            if ($urandom % 2 == 0) begin
                beats = $urandom_range(1, 6);
                base  = $urandom_range(0, DEPTH - 4 * beats);
                do_load(32'(base), 32'(beats), 1, 1'b0);
                do_read(32'(base), 32'(4 * beats), $urandom_range(0, 2));
            end else begin
                len  = $urandom_range(1, 12);
                base = $urandom_range(0, DEPTH - len);
                do_read(32'(base), 32'(len), $urandom_range(0, 2));
            end
        end

        repeat (2) @(posedge clk);
        chk("total_writes", 32'(n_wr_seen), 32'(n_wr_exp));
        chk("total_words", 32'(n_rd_seen), 32'(n_rd_exp));
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ifm_bram_ctrl.md
IFM_BRAM_CTRL -- requirements
Module: ifm_bram_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 100352: IFM buffer depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 32: width of all address and count ports.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 load_start  in  1  one-cycle pulse that starts a load phase.
REQ-006 load_base  in  ADDR_W  first word index written by the load phase.
REQ-007 load_beats  in  ADDR_W  number of 128-bit beats to load.
REQ-008 s_valid / s_ready  in / out  1  handshake for the input beat stream.
REQ-009 s_data  in  128  input beat (4 words, word 0 in bits [31:0]).
REQ-010 rd_start  in  1  one-cycle pulse that starts a read phase.
REQ-011 rd_base  in  ADDR_W  first word index read by the read phase.
REQ-012 rd_len  in  ADDR_W  number of 32-bit words to read.
REQ-013 bram_wr_rd_en  out  1  BRAM write enable.
REQ-014 bram_wr_addr  out  ADDR_W  BRAM write word address.
REQ-015 bram_rd_addr  out  ADDR_W  BRAM read byte address (word index << 2).
REQ-016 bram_data_in  out  128  BRAM write data.
REQ-017 bram_data_out  in  32  BRAM read data, registered, 1-cycle latency.
REQ-018 m_valid / m_ready  out / in  1  handshake for the output word stream.
REQ-019 m_data  out  32  output word.
REQ-020 busy, done, err  out  1 each  status; done and err are one-cycle pulses.

Function
REQ-021 FSM states: IDLE, LOAD, RD_ISSUE, RD_DRAIN, DONE.
REQ-022 IDLE -> LOAD on load_start; IDLE -> RD_ISSUE on rd_start; load_start has priority when both pulses arrive in the same cycle.
REQ-023 Start pulses received outside IDLE are ignored; base and length are latched only on an accepted start.
REQ-024 In LOAD, s_ready = 1.
REQ-025 In LOAD, each s_valid&&s_ready beat drives, combinationally in that cycle: bram_wr_rd_en=1, bram_data_in=s_data, bram_wr_addr=load_base+4*k, where k is the beat index from 0.
REQ-026 LOAD -> DONE in the cycle after the load_beats-th beat is accepted; s_ready = 0 in that cycle.
REQ-027 A read is issued by driving bram_rd_addr=(rd_base+i)<<2, where i is the word index from 0.
REQ-028 Word i is presented on m_data with m_valid=1 one cycle after its issue.
REQ-029 The controller holds a single output slot; i advances only when the slot is empty or m_valid&&m_ready in that cycle.
REQ-030 When stalled, bram_rd_addr holds its value, so the re-read data stays stable.
REQ-031 RD_ISSUE -> RD_DRAIN after rd_len words are issued; RD_DRAIN -> DONE when the last word handshakes.
REQ-032 m_data words appear in address order with none dropped or duplicated; m_valid stays high until the handshake.
REQ-033 A zero length (load_beats=0 or rd_len=0) goes straight to DONE with no BRAM or stream activity.
REQ-034 Range check at start: load_base+4*load_beats > DEPTH_WORDS, or rd_base+rd_len > DEPTH_WORDS, goes to DONE with err=1 and no accesses; the check uses ADDR_W+3-bit arithmetic, so there is no wraparound.
REQ-035 DONE lasts one cycle and pulses done (and err, if raised), then returns to IDLE.
REQ-036 busy = 1 in every state except IDLE.
REQ-037 bram_wr_rd_en = 0 outside LOAD beats; loads and reads never overlap.

Reset
REQ-038 While rst=1 at a clock edge, the FSM goes to IDLE.
REQ-039 Reset values: s_ready, m_valid, bram_wr_rd_en, busy, done, err = 0; all addresses, counters and m_data = 0.
REQ-040 Reset mid-operation abandons the phase at once: no further writes, and partial output is discarded.

Structure
REQ-041 Shared package ifm_pkg holds the FSM state enum, DEPTH_WORDS, and the word and beat width constants.
REQ-042 The output slot is one sub-module, ifm_rd_skid: a 1-entry register with valid/ready.

Verification
REQ-043 Load 3 beats with load_base=8 -> writes at 8, 12, 16 with matching data; done pulses 1 cycle after beat 3.
REQ-044 Read rd_base=5, rd_len=4, m_ready=1 -> bram_rd_addr 20, 24, 28, 32; m_data in order with 1-cycle latency; done after the 4th handshake.
REQ-045 Same read with m_ready toggling 1,0,0,1 -> exactly 4 words in order, m_data stable while stalled.
REQ-046 rd_base=100350, rd_len=4 -> err and done in the same cycle, no m_valid; rd_len=0 -> done with no reads.
REQ-047 load_start and rd_start in the same cycle -> load runs and the read is ignored.
REQ-048 rst asserted after 1 of 4 beats -> IDLE, s_ready=0, no further writes.
